// File: rtl/dbi_pkg.sv
// Shared constants and helpers for the 8-bit DBI receive path.
// Zero-count limits mirror the transmitter's inversion decision.
package dbi_pkg;

    localparam int DATA_W         = 8;
    localparam int ZERO_LIMIT_RAW = 4;  // encoder inverts when zeros exceed this
    localparam int ZERO_LIMIT_INV = 3;

    function automatic logic [3:0] zero_count(input logic [DATA_W-1:0] b);
        logic [3:0] z;
        z = 4'd0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!b[i]) z = z + 4'd1;
        end
        return z;
    endfunction

endpackage

// File: rtl/dbi_lane_decode.sv
// Conditional byte inverter: restores raw data from an encoded byte and its DBI flag.
module dbi_lane_decode
    import dbi_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              dbi,
    output logic [DATA_W-1:0] decoded
);

    logic [DATA_W-1:0] inv_bits;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        inverter1bit u_inv (
            .a (data[i]),
            .y (inv_bits[i])
        );
        assign decoded[i] = dbi ? inv_bits[i] : data[i];
    end

endmodule

// File: rtl/inverter1bit.sv
// Library 1-bit inverter cell.
module inverter1bit (
    input  logic a,
    output logic y
);

    assign y = ~a;

endmodule

// File: rtl/dbi_decoder_8bit.sv
// DBI receive decoder: valid/ready input, 2-entry skid buffer of decoded bytes,
// saturating inverted-byte counter and sticky encoding-rule error flag.
module dbi_decoder_8bit
    import dbi_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dbi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              clear_stats,
    output logic [CNT_W-1:0]  inv_count,
    output logic              rule_err
);

    logic [DATA_W-1:0] decoded;
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;
    logic              accept;
    logic              pop;
    logic [3:0]        zeros;
    logic              violation;

    dbi_lane_decode u_lane (
        .data    (in_data),
        .dbi     (in_dbi),
        .decoded (decoded)
    );

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign zeros     = zero_count(in_data);
    assign violation = in_dbi ? (zeros > 4'(ZERO_LIMIT_INV))
                              : (zeros > 4'(ZERO_LIMIT_RAW));

    // Storage needs no reset: out_data is masked whenever occ is zero.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= decoded;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            inv_count <= '0;
            rule_err  <= 1'b0;
        end else if (accept) begin
            if (in_dbi && (inv_count != {CNT_W{1'b1}}))
                inv_count <= inv_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (violation)
                rule_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbi_decoder_8bit.sv
// Bench for dbi_decoder_8bit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dbi_decoder_8bit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_dbi;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             clear_stats;
    logic [CNT_W-1:0] inv_count;
    logic             rule_err;

    int total = 0;
    int bad   = 0;

    dbi_decoder_8bit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dbi      (in_dbi),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .clear_stats (clear_stats),
        .inv_count   (inv_count),
        .rule_err    (rule_err)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of raw bytes plus plain counters.
    logic [7:0] mq[$];
    int         m_cnt = 0;
    bit         m_err = 1'b0;

    always @(posedge clk) begin
        bit         acc, pp, viol;
        int         z;
        logic [7:0] raw;
        if (reset) begin
            mq.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            acc  = in_valid && (mq.size() < 2);
            pp   = (mq.size() > 0) && out_ready;
            z    = 8 - $countones(in_data);
            viol = in_dbi ? (z > 3) : (z > 4);
            raw  = in_dbi ? ~in_data : in_data;
            if (pp)  void'(mq.pop_front());
            if (acc) mq.push_back(raw);
            if (clear_stats) begin
                m_cnt = 0;
                m_err = 1'b0;
            end else if (acc) begin
                if (in_dbi && m_cnt < CNT_MAX) m_cnt++;
                if (viol) m_err = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("m_in_ready",  int'(in_ready),  int'(mq.size() < 2));
            check("m_out_valid", int'(out_valid), int'(mq.size() > 0));
            check("m_out_data",  int'(out_data),  (mq.size() > 0) ? int'(mq[0]) : 0);
            check("m_inv_count", int'(inv_count), m_cnt);
            check("m_rule_err",  int'(rule_err),  int'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the byte until in_ready is seen high before an edge, then returns after that edge.
    task automatic send(input logic [7:0] d, input logic dbi);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_dbi   = dbi;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                step();
                break;
            end
            n++;
            if (n > 50) begin
                check("send_timeout", 0, 1);
                step();
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_dbi   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dbi = 1'b0;
        out_ready = 1'b0; clear_stats = 1'b0;
        step(); step();
        reset = 1'b0;

        @(negedge clk);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_inv_count", int'(inv_count), 0);
        check("rst_rule_err",  int'(rule_err),  0);
        step();

        out_ready = 1'b1;
        send(8'hF7, 1'b1);
        idle();
        @(negedge clk);
        check("f7_out_data",  int'(out_data),  8'h08);
        check("f7_out_valid", int'(out_valid), 1);
        check("f7_inv_count", int'(inv_count), 1);
        check("f7_rule_err",  int'(rule_err),  0);
        step();

        send(8'hF0, 1'b0);
        @(negedge clk);
        check("f0_out_data", int'(out_data), 8'hF0);
        check("f0_rule_err", int'(rule_err), 0);
        send(8'h01, 1'b0);
        idle();
        @(negedge clk);
        check("01_out_data",  int'(out_data),  8'h01);
        check("01_rule_err",  int'(rule_err),  1);
        check("01_inv_count", int'(inv_count), 1);
        step(); step();

        out_ready = 1'b0;
        send(8'h3F, 1'b0);
        send(8'h7E, 1'b0);
        in_data = 8'hFF;
        step(); step();
        @(negedge clk);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_head",     int'(out_data), 8'h3F);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_0", int'(out_data), 8'h3F);
        step();
        @(negedge clk);
        check("drain_1",       int'(out_data), 8'h7E);
        check("drain_1_ready", int'(in_ready), 1);
        step();
        idle();
        @(negedge clk);
        check("drain_2", int'(out_data), 8'hFF);
        step();
        @(negedge clk);
        check("drain_empty", int'(out_valid), 0);
        step();

        clear_stats = 1'b1;
        send(8'h55, 1'b1);
        clear_stats = 1'b0;
        idle();
        @(negedge clk);
        check("clr_inv_count", int'(inv_count), 0);
        check("clr_rule_err",  int'(rule_err),  0);
        step(); step();

        out_ready = 1'b0;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        idle();
        @(negedge clk);
        check("full_in_ready", int'(in_ready), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_full_out_valid", int'(out_valid), 0);
        check("rst_full_in_ready",  int'(in_ready),  1);
        check("rst_full_out_data",  int'(out_data),  0);

        out_ready = 1'b1;
        for (int i = 0; i < CNT_MAX; i++) send(8'h0F, 1'b1);
        idle();
        @(negedge clk);
        check("sat_reach", int'(inv_count), CNT_MAX);
        send(8'h0F, 1'b1);
        idle();
        @(negedge clk);
        check("sat_hold", int'(inv_count), CNT_MAX);
        step(); step();

        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = 8'($urandom);
            in_dbi      = 1'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            clear_stats = ($urandom_range(0, 31) == 0);
            reset       = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; clear_stats = 1'b0;
        idle();
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbi_decoder_8bit.md
Name: dbi_decoder_8bit

Overview:
- Receive-side decoder for an 8-bit data-bus-inversion (DBI) link. The transmit side inverts a byte before sending it when the raw byte has more than 4 zero bits, and flags that with a DBI bit.
- This block takes encoded bytes plus the DBI flag over a valid/ready handshake and re-inverts flagged bytes to recover raw data.
- It buffers decoded data in a 2-entry skid buffer, counts inverted bytes, and flags frames that break the encoding rule.

Parameters:
- CNT_W, 16, width of the saturating inverted-byte counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  encoded byte present on in_data/in_dbi.
- in_ready  output  1  decoder can accept a byte this cycle.
- in_data  input  8  encoded byte.
- in_dbi  input  1  1 = in_data was inverted by the transmitter.
- out_valid  output  1  decoded byte available.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  8  decoded raw byte.
- clear_stats  input  1  synchronous clear of inv_count and rule_err.
- inv_count  output  CNT_W  number of accepted bytes with in_dbi=1, saturating.
- rule_err  output  1  sticky; an accepted byte violated the DBI rule.

Behaviour:
- Reset (reset=1 at an edge): buffer emptied (occupancy 0), write/read pointers 0, inv_count=0, rule_err=0. Outputs then read in_ready=1, out_valid=0, out_data=0. Reset overrides every other input, including mid-transfer; buffered bytes are discarded.
- Decode: decoded = in_dbi ? ~in_data : in_data. Decode is combinational at the input; the buffer stores decoded bytes only.
- Accept: accept = in_valid & in_ready. Pop: pop = out_valid & out_ready.
- Buffer: 2 entries, occupancy 0..2. in_ready = (occ < 2). out_valid = (occ > 0). out_data = entry at the read pointer, and is 0 when empty.
- Latency: a byte accepted at edge N is on out_data with out_valid=1 immediately after edge N. With out_ready held at 1 the path sustains 1 byte/cycle.
- occ=0: accept only, so occ goes to 1. A pop is impossible.
- occ=1: accept and pop may happen in the same cycle; occ stays 1, and the new byte follows the popped one.
- occ=2: in_ready=0, so no accept. A pop takes occ to 1.
- Ordering is strict FIFO. Pointers are 1 bit and wrap 1→0.
- in_data/in_dbi are ignored when accept=0. out_data must hold stable while out_valid=1 and out_ready=0.
- Rule check, on accept only, with z = number of zero bits in in_data:
  - violation if in_dbi=1 and z>3;
  - violation if in_dbi=0 and z>4.
  - A violation sets rule_err=1 at that edge. The byte is still decoded and buffered normally.
- inv_count: +1 on each accept with in_dbi=1; saturates at all-ones and holds.
- clear_stats=1 at an edge: inv_count←0 and rule_err←0. Clear has priority, so any count or error event in that same cycle is dropped. clear_stats does not affect the buffer.

Decomposition:
- Package dbi_pkg holds:
  - DATA_W=8;
  - ZERO_LIMIT_RAW=4 (encoder inverts when zeros > this);
  - ZERO_LIMIT_INV=3;
  - a function returning the zero count of a byte.
- Sub-module dbi_lane_decode: combinational conditional inverter (data, dbi → decoded). It is built from 8 inverter1bit instances muxed by dbi, reusing the existing 1-bit inverter cell.
- Handshake, buffer and stats logic live in the top.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, out_data=0x00, inv_count=0, rule_err=0.
- Send 0xF7 with dbi=1 and out_ready=1 → out_data=0x08 the cycle after accept; inv_count=1; rule_err=0.
- Send 0xF0 dbi=0, then 0x01 dbi=0 → outputs 0xF0 then 0x01, in that order. rule_err=1 after the second accept (7 zeros); inv_count unchanged.
- Hold out_ready=0 and send 0x3F, 0x7E, 0xFF (all dbi=0):
  - the first two are accepted, then in_ready=0 and the third stalls;
  - then raise out_ready=1 → output order is 0x3F, 0x7E, 0xFF, with no loss or duplication.
- Overrides:
  - Pulse clear_stats on the same cycle as an accept with dbi=1 → inv_count=0 afterwards and that event is not counted.
  - Assert reset with occ=2 → next cycle occ=0, out_valid=0, in_ready=1.
- Saturation: force inv_count to all-ones (CNT_W=4 build: 15 dbi=1 bytes), then 1 more dbi=1 byte → inv_count stays 15.
